// File: rtl/pc_reg_pkg.sv
// pc_reg_pkg: shared constants for the instruction-fetch program counter.
//   INST_ADDR_W   - instruction address width
//   inst_addr_t   - instruction address type
//   CHIP_ENABLE / CHIP_DISABLE - ROM chip-enable levels
//   ZERO_WORD     - all-zero address word
//   RESET_VECTOR  - default first fetch address after reset
//   PC_STEP       - sequential fetch increment (one 32-bit instruction)
package pc_reg_pkg;

  localparam int INST_ADDR_W = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  localparam logic       CHIP_ENABLE  = 1'b1;
  localparam logic       CHIP_DISABLE = 1'b0;
  localparam inst_addr_t ZERO_WORD    = '0;
  localparam inst_addr_t RESET_VECTOR = ZERO_WORD;
  localparam inst_addr_t PC_STEP      = inst_addr_t'(4);

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter for the fetch stage.
//   clk                - clock, all state updates on rising edge
//   rst_n              - asynchronous active-low reset
//   stall              - hold pc this cycle
//   flush              - redirect fetch to new_pc (highest priority)
//   new_pc             - flush redirect target
//   branch_flag        - branch/jump resolved taken in decode
//   branch_target_addr - taken-branch target
//   pc                 - registered fetch address to the instruction ROM
//   ce                 - registered ROM chip enable
//   pc_misalign        - fetch address is not word-aligned (only while ce)
//
// A taken branch that arrives while the pipeline is stalled must not be
// lost: it is parked in a pending register and applied on the first cycle
// the stall releases, unless a flush or a fresh branch supersedes it.
module pc_reg
  import pc_reg_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] branch_target_addr,
  output logic [INST_ADDR_W-1:0] pc,
  output logic                   ce,
  output logic                   pc_misalign
);

  logic                   pend_valid_reg;
  logic [INST_ADDR_W-1:0] pend_addr_reg;

  logic [INST_ADDR_W-1:0] pc_next;
  logic                   pend_valid_next;
  logic [INST_ADDR_W-1:0] pend_addr_next;

  // Next-state selection. While ce is low, every control input is ignored
  // so the first enabled cycle always presents RESET_PC to the ROM.
  always_comb begin
    pc_next         = pc;
    pend_valid_next = pend_valid_reg;
    pend_addr_next  = pend_addr_reg;
    if (ce == CHIP_ENABLE) begin
      if (flush) begin
        pc_next         = new_pc;
        pend_valid_next = 1'b0;
        pend_addr_next  = ZERO_WORD;
      end else if (stall) begin
        // Latest branch seen during the stall wins.
        if (branch_flag) begin
          pend_valid_next = 1'b1;
          pend_addr_next  = branch_target_addr;
        end
      end else if (branch_flag) begin
        pc_next         = branch_target_addr;
        pend_valid_next = 1'b0;
      end else if (pend_valid_reg) begin
        pc_next         = pend_addr_reg;
        pend_valid_next = 1'b0;
      end else begin
        // Wraps modulo 2^32; the carry out is deliberately dropped.
        pc_next = pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      ce             <= CHIP_DISABLE;
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= ZERO_WORD;
    end else begin
      pc             <= pc_next;
      ce             <= CHIP_ENABLE;
      pend_valid_reg <= pend_valid_next;
      pend_addr_reg  <= pend_addr_next;
    end
  end

  // Misaligned addresses are reported, never silently corrected.
  assign pc_misalign = (ce == CHIP_ENABLE) && (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: table-driven check of pc_reg with an expected-value queue.
module tb_pc_reg;
  import pc_reg_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             branch_flag;
  logic [31:0]      branch_target_addr;
  logic [31:0]      pc;
  logic             ce;
  logic             pc_misalign;

  pc_reg #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall              (stall),
    .flush              (flush),
    .new_pc             (new_pc),
    .branch_flag        (branch_flag),
    .branch_target_addr (branch_target_addr),
    .pc                 (pc),
    .ce                 (ce),
    .pc_misalign        (pc_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_ce;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        mis;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic s, logic f, logic [31:0] np, logic b,
                              logic [31:0] t, logic [31:0] epc, logic ece,
                              logic emis);
    vec_t v;
    v.stall = s; v.flush = f; v.new_pc = np; v.br = b; v.tgt = t;
    v.exp_pc = epc; v.exp_ce = ece; v.exp_mis = emis;
    return v;
  endfunction

  task automatic check32(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic check1(string name, int idx, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // pop and compare once the DUT has produced them.
  task automatic apply(vec_t v, int idx);
    exp_t e;
    exp_t got;
    stall = v.stall; flush = v.flush; new_pc = v.new_pc;
    branch_flag = v.br; branch_target_addr = v.tgt;
    e.pc = v.exp_pc; e.ce = v.exp_ce; e.mis = v.exp_mis; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard [%0d]: queue empty, expected one entry", idx);
    end else begin
      got = sb.pop_front();
      check32("pc", got.idx, pc, got.pc);
      check1("ce", got.idx, ce, got.ce);
      check1("pc_misalign", got.idx, pc_misalign, got.mis);
      $display("vec %0d: stall=%b flush=%b br=%b -> pc=0x%08h ce=%b mis=%b",
               got.idx, v.stall, v.flush, v.br, pc, ce, pc_misalign);
    end
  endtask

  initial begin
    // Main table: {stall, flush, new_pc, branch, target, exp pc, exp ce, exp mis}
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0000,1,0)); // first enabled: RESET_PC
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0004,1,0));
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0008,1,0));
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_000C,1,0));
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0010,1,0));
    vecs.push_back(mk(0,0,0,1,32'h100,   32'h0000_0100,1,0)); // taken branch
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0104,1,0));
    vecs.push_back(mk(0,1,32'h20,0,0,    32'h0000_0020,1,0)); // reposition
    vecs.push_back(mk(1,0,0,0,0,         32'h0000_0020,1,0)); // stall 1
    vecs.push_back(mk(1,0,0,1,32'h200,   32'h0000_0020,1,0)); // stall 2 + branch
    vecs.push_back(mk(1,0,0,0,0,         32'h0000_0020,1,0)); // stall 3
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0200,1,0)); // pending applied
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0204,1,0));
    vecs.push_back(mk(1,1,32'h180,1,32'h300, 32'h0000_0180,1,0)); // flush wins
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0184,1,0)); // no stale pending
    vecs.push_back(mk(1,0,0,1,32'h500,   32'h0000_0184,1,0));
    vecs.push_back(mk(1,0,0,1,32'h600,   32'h0000_0184,1,0)); // overwrite pending
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0600,1,0));
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0604,1,0));
    vecs.push_back(mk(1,0,0,1,32'h800,   32'h0000_0604,1,0));
    vecs.push_back(mk(0,0,0,1,32'h900,   32'h0000_0900,1,0)); // fresh branch beats pending
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0904,1,0)); // pending cleared
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC,1,0));
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0000,1,0)); // wrap
    vecs.push_back(mk(0,0,0,1,32'h102,   32'h0000_0102,1,1)); // misaligned
    vecs.push_back(mk(0,0,0,0,0,         32'h0000_0106,1,1)); // not realigned
    vecs.push_back(mk(0,1,32'h40,0,0,    32'h0000_0040,1,0));
    vecs.push_back(mk(1,0,0,1,32'h400,   32'h0000_0040,1,0)); // pending 0x400

    rst_n = 1'b0; stall = 0; flush = 0; new_pc = '0;
    branch_flag = 0; branch_target_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    check32("reset_pc", -1, pc, 32'h0);
    check1("reset_ce", -1, ce, 1'b0);
    check1("reset_mis", -1, pc_misalign, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset mid-stall with a pending branch: asynchronous clear.
    stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check32("async_rst_pc", 100, pc, 32'h0);
    check1("async_rst_ce", 100, ce, 1'b0);
    check1("async_rst_mis", 100, pc_misalign, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // Controls are ignored on the edge that enables the ROM.
    apply(mk(1,1,32'h999,1,32'h444, 32'h0000_0000,1,0), 101);
    apply(mk(0,0,0,0,0,             32'h0000_0004,1,0), 102);
    apply(mk(0,0,0,0,0,             32'h0000_0008,1,0), 103); // 0x400 never fetched

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pc_reg.md
PC_REG -- requirements
Module: pc_reg

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: stall  input  1  hold PC this cycle (from pipeline control).
REQ-005 SHALL have port: flush  input  1  redirect fetch to new_pc (exception/eret).
REQ-006 SHALL have port: new_pc  input  `Inst_Addr  flush redirect target.
REQ-007 SHALL have port: branch_flag  input  1  branch/jump resolved taken in decode.
REQ-008 SHALL have port: branch_target_addr  input  `Inst_Addr  taken-branch target.
REQ-009 SHALL have port: pc  output  `Inst_Addr  fetch address to instruction ROM, registered.
REQ-010 SHALL have port: ce  output  1  ROM chip enable, registered (`Chip_Enable/`Chip_Disable).
REQ-011 SHALL have port: pc_misalign  output  1  fetch address not word-aligned.

Function
REQ-012 SHALL drive ce = `Chip_Disable during reset and assert `Chip_Enable on the first rising clk edge after rst_n deasserts, holding it thereafter.
REQ-013 SHALL hold pc = RESET_PC while ce is disabled; the first enabled cycle presents RESET_PC to the ROM.
REQ-014 SHALL, on each edge with ce enabled, update pc by strict priority: flush > stall > branch_flag > pending branch > pc + 4.
REQ-015 SHALL on flush load pc = new_pc and clear the pending-branch register, regardless of stall or branch_flag.
REQ-016 SHALL on stall (no flush) hold pc unchanged.
REQ-017 SHALL, when branch_flag is high during a stall, capture branch_target_addr into a pending register (pend_valid=1); a later branch during the same stall overwrites it.
REQ-018 SHALL on branch_flag without stall load pc = branch_target_addr and clear pend_valid.
REQ-019 SHALL, on the first non-stalled, non-flush cycle with pend_valid=1 and branch_flag=0, load pc = pending address and clear pend_valid.
REQ-020 SHALL compute pc + 4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000, no carry out).
REQ-021 SHALL ignore flush, stall and branch_flag while ce is disabled.
REQ-022 SHALL drive pc_misalign = ce AND (pc[1:0] != 0), combinational from registered pc; pc is never auto-realigned.
REQ-023 SHALL produce pc one cycle after the controlling inputs (single-cycle redirect latency).

Reset
REQ-024 SHALL on rst_n low asynchronously set pc = RESET_PC, ce = `Chip_Disable, pend_valid = 0, pending address = `Zero_Word.
REQ-025 SHALL, on reset asserted mid-operation (including with a pending branch), discard all in-flight state and restart per REQ-012/013.

Structure
REQ-026 SHALL take `Inst_Addr, `Chip_Enable, `Chip_Disable, `Zero_Word and the reset-vector constant from the shared define.v header; no new local width literals.
REQ-027 SHALL be a single module with no sub-modules; pending-branch register is internal.

Verification
REQ-028 Reset release, no stall: ce 0 -> 1 at first edge; pc sequence 0x0, 0x4, 0x8, 0xC on successive enabled cycles.
REQ-029 At pc=0x10, branch_flag=1, target=0x100 -> next pc 0x100, then 0x104.
REQ-030 stall high 3 cycles at pc=0x20 with branch_flag pulse (target 0x200) in cycle 2 -> pc holds 0x20, then 0x200 on release, then 0x204.
REQ-031 flush=1, new_pc=0x180, simultaneous stall=1 and branch_flag=1 (target 0x300) -> pc 0x180, pend_valid 0, then 0x184.
REQ-032 pc=0xFFFF_FFFC, no control -> pc 0x0000_0000; branch to 0x102 -> pc_misalign=1 while pc=0x102.
REQ-033 rst_n pulsed low mid-stall with pending branch 0x400 -> pc 0x0, ce 0 immediately; after release sequence 0x0, 0x4 (0x400 never fetched).
